// File: rtl/hlsm_seq_pkg.sv
// Shared types and constants for the HLSM start sequencer.
//   seq_state_e  : sequencer FSM state (IDLE, LAUNCH, WAIT, EMIT)
//   OPS_W        : width of one packed operand set {a..f} at the default DATAW
//   HLSM_NOM_LAT : nominal Start-to-Done distance of the scheduled HLSM core
//   ops_width()  : packed operand-set width for an arbitrary DATAW
package hlsm_seq_pkg;

  localparam int unsigned OPS_PER_SET  = 6;
  localparam int unsigned DATAW_DEF    = 16;
  localparam int unsigned OPS_W        = OPS_PER_SET * DATAW_DEF;
  localparam int unsigned HLSM_NOM_LAT = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    EMIT   = 2'd3
  } seq_state_e;

  function automatic int unsigned ops_width(input int unsigned dataw);
    return OPS_PER_SET * dataw;
  endfunction

endpackage

// File: rtl/hlsm_op_fifo.sv
// Operand-set queue for the HLSM start sequencer.
// DEPTH entries of WIDTH bits; DEPTH must be a power of two, >= 2.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push       : write i_wdata (ignored when full unless popping the same cycle)
//   i_wdata      : entry to write
//   i_pop        : retire the head entry
//   o_full       : DEPTH entries held
//   o_empty      : no entries held
//   o_head       : head entry, zero when empty
module hlsm_op_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full  = (r_count == (PtrW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

  // Simultaneous push/pop is accepted at both boundaries so the count stays put;
  // on an empty queue the pushed entry is consumed as it lands.
  assign w_do_push = i_push & (~o_full  | i_pop);
  assign w_do_pop  = i_pop  & (~o_empty | i_push);

  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage carries no reset; validity is tracked by the count.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + (PtrW+1)'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - (PtrW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/hlsm_start_sequencer.sv
// Initiator side of the HLSM Start/Done handshake. Operand sets are queued, the head
// set is driven onto a..f, Start is pulsed for one cycle, and j/k are captured when
// Done arrives and returned through a valid/ready result port. A set whose Done does
// not arrive within TIMEOUT cycles of Start is dropped and err_timeout is latched.
// Ports:
//   Clk, Rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand-set push handshake
//   in_ops                : {a,b,c,d,e,f}, a in the MSBs
//   Start, Done           : HLSM handshake (Done qualifies j_in/k_in for that cycle only)
//   a..f                  : head operand set, zero when the queue is empty
//   j_in, k_in            : HLSM results
//   res_valid/res_ready   : result handshake, res_j/res_k held until accepted
//   busy                  : FSM outside IDLE
//   err_timeout           : sticky abort flag, cleared only by Rst
// Build option HLSM_SEQ_LATMON_EN adds lat_cycles[7:0]: Start-to-Done distance of the
// last successful capture (unchanged on timeout).
module hlsm_start_sequencer #(
  parameter int unsigned DATAW   = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [6*DATAW-1:0]      in_ops,
  output logic                    Start,
  input  logic                    Done,
  output logic signed [DATAW-1:0] a,
  output logic signed [DATAW-1:0] b,
  output logic signed [DATAW-1:0] c,
  output logic signed [DATAW-1:0] d,
  output logic signed [DATAW-1:0] e,
  output logic signed [DATAW-1:0] f,
  input  logic signed [DATAW-1:0] j_in,
  input  logic signed [DATAW-1:0] k_in,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [DATAW-1:0] res_j,
  output logic signed [DATAW-1:0] res_k,
  output logic                    busy,
  output logic                    err_timeout
`ifdef HLSM_SEQ_LATMON_EN
  ,
  output logic [7:0]              lat_cycles
`endif
);

  import hlsm_seq_pkg::*;

  localparam int unsigned OpsW   = ops_width(DATAW);
  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  seq_state_e r_state;
  logic              r_start;
  logic              r_busy;
  logic              r_res_valid;
  logic [DATAW-1:0]  r_res_j;
  logic [DATAW-1:0]  r_res_k;
  logic              r_err;
  logic [TimerW-1:0] r_timer;
`ifdef HLSM_SEQ_LATMON_EN
  logic [7:0]        r_lat;
`endif

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [OpsW-1:0]   w_head;
  logic [TimerW-1:0] w_timer_inc;
  logic              w_timer_hit;

  assign in_ready = ~w_full;
  assign w_push   = in_valid & ~w_full;

  // w_timer_inc is the Start-to-now distance of the current WAIT cycle.
  assign w_timer_inc = r_timer + TimerW'(1);
  assign w_timer_hit = (w_timer_inc == TimerW'(TIMEOUT));

  // The in-flight set stays at the head until it completes or is dropped.
  assign w_pop = (r_state == WAIT) & (Done | w_timer_hit);

  hlsm_op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OpsW)
  ) u_op_fifo (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_push  (w_push),
    .i_wdata (in_ops),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign {a, b, c, d, e, f} = w_head;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_j     <= '0;
      r_res_k     <= '0;
      r_err       <= 1'b0;
      r_timer     <= '0;
`ifdef HLSM_SEQ_LATMON_EN
      r_lat       <= '0;
`endif
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!w_empty && !r_res_valid) begin
            r_state <= LAUNCH;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        LAUNCH: begin
          r_timer <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_timer <= w_timer_inc;
          // Done on the timeout cycle still wins.
          if (Done) begin
            r_res_j     <= j_in;
            r_res_k     <= k_in;
            r_res_valid <= 1'b1;
            r_state     <= EMIT;
`ifdef HLSM_SEQ_LATMON_EN
            r_lat       <= 8'(w_timer_inc);
`endif
          end else if (w_timer_hit) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        EMIT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Start       = r_start;
  assign busy        = r_busy;
  assign res_valid   = r_res_valid;
  assign res_j       = r_res_j;
  assign res_k       = r_res_k;
  assign err_timeout = r_err;
`ifdef HLSM_SEQ_LATMON_EN
  assign lat_cycles  = r_lat;
`endif

endmodule

// File: tb/tb_hlsm_start_sequencer.sv
// Directed bench for hlsm_start_sequencer. A behavioural HLSM computes
// j = (a*b + c)*d, k = e*f and raises Done hlsm_lat cycles after Start; done_en=0
// turns it into a stub that never answers, force_done injects a stray Done.
module tb_hlsm_start_sequencer;
  import hlsm_seq_pkg::*;

  logic               Clk;
  logic               Rst;
  logic               in_valid;
  logic               in_ready;
  logic [95:0]        in_ops;
  logic               Start;
  logic               Done;
  logic signed [15:0] op_a, op_b, op_c, op_d, op_e, op_f;
  logic signed [15:0] j_in, k_in;
  logic               res_valid;
  logic               res_ready;
  logic signed [15:0] res_j, res_k;
  logic               busy;
  logic               err_timeout;
`ifdef HLSM_SEQ_LATMON_EN
  logic [7:0]         lat_cycles;
`endif

  int n_vec;
  int n_bad;

  hlsm_start_sequencer #(
    .DATAW   (16),
    .DEPTH   (4),
    .TIMEOUT (15)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ops      (in_ops),
    .Start       (Start),
    .Done        (Done),
    .a           (op_a),
    .b           (op_b),
    .c           (op_c),
    .d           (op_d),
    .e           (op_e),
    .f           (op_f),
    .j_in        (j_in),
    .k_in        (k_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_j       (res_j),
    .res_k       (res_k),
    .busy        (busy),
    .err_timeout (err_timeout)
`ifdef HLSM_SEQ_LATMON_EN
    ,
    .lat_cycles  (lat_cycles)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural HLSM
  int                 hlsm_lat;
  logic               done_en;
  logic               force_done;
  logic               h_act;
  int                 hc;
  logic               model_done;
  logic signed [15:0] j_calc, k_calc;

  always @(posedge Clk) begin
    if (Rst) begin
      h_act <= 1'b0;
      hc    <= 0;
    end else if (Start) begin
      h_act <= 1'b1;
      hc    <= 1;
    end else if (h_act) begin
      if (model_done) h_act <= 1'b0;
      hc <= hc + 1;
    end
  end

  assign model_done = h_act && done_en && (hc == hlsm_lat);
  assign Done       = force_done | model_done;
  assign j_calc     = (op_a * op_b + op_c) * op_d;
  assign k_calc     = op_e * op_f;
  assign j_in = force_done ? 16'sh1234 : (model_done ? j_calc : 16'sh5A5A);
  assign k_in = force_done ? 16'sh4321 : (model_done ? k_calc : 16'sh0F0F);

  function automatic logic [95:0] mk(input int va, vb, vc, vd, ve, vf);
    return {16'(va), 16'(vb), 16'(vc), 16'(vd), 16'(ve), 16'(vf)};
  endfunction

  task automatic do_reset();
    Rst = 1'b1; in_valid = 1'b0; res_ready = 1'b1; force_done = 1'b0;
    done_en = 1'b1; hlsm_lat = HLSM_NOM_LAT;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  // Offers one set and returns on the negedge after it was accepted.
  task automatic push_set(input logic [95:0] ops, output bit ok);
    ok = 1'b0; in_valid = 1'b1; in_ops = ops;
    for (int i = 0; i < 60; i++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        @(negedge Clk);
        break;
      end
      @(negedge Clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Start === 1'b1) begin ok = 1'b1; break; end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    n_vec++; if (Start !== 1'b0) begin n_bad++; $display("FAIL rst_start got=%b exp=0", Start); end
    n_vec++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
    n_vec++; if ({res_j, res_k} !== 32'h0) begin n_bad++; $display("FAIL rst_res_jk got=%h exp=0", {res_j, res_k}); end
    n_vec++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b exp=0", err_timeout); end
    n_vec++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_busy_ready got=%b%b exp=01", busy, in_ready); end
    n_vec++; if ({op_a, op_b, op_c, op_d, op_e, op_f} !== 96'h0) begin n_bad++; $display("FAIL rst_ops got=%h exp=0", {op_a, op_b, op_c, op_d, op_e, op_f}); end
`ifdef HLSM_SEQ_LATMON_EN
    n_vec++; if (lat_cycles !== 8'd0) begin n_bad++; $display("FAIL rst_lat got=%0d exp=0", lat_cycles); end
`endif
    Rst = 1'b0;
  endtask

  // Vectors 1 and 2 back to back: exact 10-cycle round trip and signed pass-through.
  task automatic test_basic_pair();
    bit ok1, ok2, ok3;
    do_reset();
    push_set(mk(2, 3, 4, 5, 6, 7), ok1);
    push_set(mk(-2, 3, 1, 4, -1, -1), ok2);
    wait_start(ok3);
    n_vec++; if (!(ok1 && ok2 && ok3)) begin n_bad++; $display("FAIL basic_launch got=%b%b%b exp=111", ok1, ok2, ok3); end
    n_vec++; if ({op_a, op_b, op_c, op_d, op_e, op_f} !== mk(2, 3, 4, 5, 6, 7) || busy !== 1'b1) begin
      n_bad++; $display("FAIL basic_ops got=%h busy=%b exp=%h busy=1", {op_a, op_b, op_c, op_d, op_e, op_f}, busy, mk(2, 3, 4, 5, 6, 7));
    end
    for (int dd = 1; dd <= 19; dd++) begin
      @(negedge Clk);
      if (dd == 1) begin
        n_vec++; if (Start !== 1'b0) begin n_bad++; $display("FAIL basic_start_pulse got=%b exp=0", Start); end
      end
      if (dd == 7) begin
        n_vec++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid got=%b exp=0", res_valid); end
      end
      if (dd == 8) begin
        n_vec++; if (res_valid !== 1'b1 || res_j !== 16'sd50 || res_k !== 16'sd42) begin
          n_bad++; $display("FAIL v1_result got=v%b j=%0d k=%0d exp=v1 j=50 k=42", res_valid, res_j, res_k);
        end
      end
      if (dd == 9) begin
        n_vec++; if (res_valid !== 1'b0 || busy !== 1'b0 || Start !== 1'b0) begin
          n_bad++; $display("FAIL v1_idle got=v%b busy%b start%b exp=000", res_valid, busy, Start);
        end
`ifdef HLSM_SEQ_LATMON_EN
        n_vec++; if (lat_cycles !== 8'd7) begin n_bad++; $display("FAIL v1_lat got=%0d exp=7", lat_cycles); end
`endif
      end
      if (dd == 10) begin
        n_vec++; if (Start !== 1'b1 || {op_a, op_b, op_c, op_d, op_e, op_f} !== mk(-2, 3, 1, 4, -1, -1)) begin
          n_bad++; $display("FAIL v2_launch got=start%b ops=%h exp=start1 ops=%h", Start, {op_a, op_b, op_c, op_d, op_e, op_f}, mk(-2, 3, 1, 4, -1, -1));
        end
      end
      if (dd == 18) begin
        n_vec++; if (res_valid !== 1'b1 || res_j !== -16'sd20 || res_k !== 16'sd1) begin
          n_bad++; $display("FAIL v2_result got=v%b j=%0d k=%0d exp=v1 j=-20 k=1", res_valid, res_j, res_k);
        end
      end
    end
  endtask

  // Vector 3: five sets, consumer stalled, then drained in push order.
  task automatic test_back_to_back();
    int exp_j[5] = '{2, 12, 14, -30, -100};
    int exp_k[5] = '{1, 10, -12, 49, 64};
    logic [95:0] sets[5];
    bit ok;
    int nok;
    int k;
    sets[0] = mk(1, 1, 1, 1, 1, 1);
    sets[1] = mk(2, 2, 0, 3, 2, 5);
    sets[2] = mk(3, -1, 10, 2, -3, 4);
    sets[3] = mk(0, 9, -5, 6, 7, 7);
    sets[4] = mk(10, 10, 0, -1, -8, -8);
    do_reset();
    res_ready = 1'b0;
    nok = 0;
    for (int i = 0; i < 4; i++) begin
      push_set(sets[i], ok);
      if (ok) nok++;
    end
    n_vec++; if (nok != 4 || in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full got=acc%0d ready%b exp=acc4 ready0", nok, in_ready); end
    push_set(sets[4], ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL b2b_fifth got=0 exp=accepted"); end
    for (int i = 0; i < 30 && res_valid !== 1'b1; i++) @(negedge Clk);
    for (int i = 0; i < 6; i++) begin
      force_done = (i == 2);
      n_vec++; if (res_valid !== 1'b1 || res_j !== 16'sd2 || res_k !== 16'sd1 || Start !== 1'b0) begin
        n_bad++; $display("FAIL b2b_hold[%0d] got=v%b j=%0d k=%0d start%b exp=v1 j=2 k=1 start0", i, res_valid, res_j, res_k, Start);
      end
      @(negedge Clk);
    end
    force_done = 1'b0;
    n_vec++; if (res_j !== 16'sd2 || in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_stray_done got=j%0d ready%b exp=j2 ready0", res_j, in_ready); end
    res_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 100 && k < 5; i++) begin
      if (res_valid === 1'b1) begin
        n_vec++; if (res_j !== 16'(exp_j[k]) || res_k !== 16'(exp_k[k])) begin
          n_bad++; $display("FAIL b2b_order[%0d] got=j%0d k%0d exp=j%0d k%0d", k, res_j, res_k, exp_j[k], exp_k[k]);
        end
        k++;
      end
      @(negedge Clk);
    end
    n_vec++; if (k != 5) begin n_bad++; $display("FAIL b2b_count got=%0d exp=5", k); end
  endtask

  task automatic test_done_ignored();
    do_reset();
    force_done = 1'b1;
    @(negedge Clk);
    force_done = 1'b0;
    @(negedge Clk);
    n_vec++; if (res_valid !== 1'b0 || busy !== 1'b0 || res_j !== 16'sd0) begin
      n_bad++; $display("FAIL idle_done got=v%b busy%b j%0d exp=v0 busy0 j0", res_valid, busy, res_j);
    end
  endtask

  // Vector 4: HLSM never answers; set dropped after 15 cycles, next set launches.
  task automatic test_timeout();
    bit ok1, ok2, ok3;
    do_reset();
    done_en = 1'b0;
    push_set(mk(1, 1, 1, 1, 1, 1), ok1);
    push_set(mk(2, 2, 0, 3, 2, 5), ok2);
    wait_start(ok3);
    n_vec++; if (!(ok1 && ok2 && ok3)) begin n_bad++; $display("FAIL to_launch got=%b%b%b exp=111", ok1, ok2, ok3); end
    for (int dd = 1; dd <= 17; dd++) begin
      @(negedge Clk);
      if (dd == 15) begin
        n_vec++; if (err_timeout !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL to_early got=err%b busy%b exp=err0 busy1", err_timeout, busy); end
      end
      if (dd == 16) begin
        n_vec++; if (err_timeout !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
          n_bad++; $display("FAIL to_abort got=err%b busy%b v%b exp=err1 busy0 v0", err_timeout, busy, res_valid);
        end
`ifdef HLSM_SEQ_LATMON_EN
        n_vec++; if (lat_cycles !== 8'd0) begin n_bad++; $display("FAIL to_lat got=%0d exp=0", lat_cycles); end
`endif
      end
      if (dd == 17) begin
        n_vec++; if (Start !== 1'b1 || op_a !== 16'sd2 || op_f !== 16'sd5 || err_timeout !== 1'b1) begin
          n_bad++; $display("FAIL to_next got=start%b a%0d f%0d err%b exp=start1 a2 f5 err1", Start, op_a, op_f, err_timeout);
        end
      end
    end
  endtask

  task automatic test_done_at_timeout();
    bit ok1, ok2;
    do_reset();
    hlsm_lat = 15;
    push_set(mk(3, -1, 10, 2, -3, 4), ok1);
    wait_start(ok2);
    for (int dd = 1; dd <= 17; dd++) begin
      @(negedge Clk);
      if (dd == 16) begin
        n_vec++; if (!(ok1 && ok2) || res_valid !== 1'b1 || res_j !== 16'sd14 || res_k !== -16'sd12 || err_timeout !== 1'b0) begin
          n_bad++; $display("FAIL edge_done got=v%b j%0d k%0d err%b exp=v1 j14 k-12 err0", res_valid, res_j, res_k, err_timeout);
        end
      end
`ifdef HLSM_SEQ_LATMON_EN
      if (dd == 17) begin
        n_vec++; if (lat_cycles !== 8'd15) begin n_bad++; $display("FAIL edge_lat got=%0d exp=15", lat_cycles); end
      end
`endif
    end
  endtask

  // Vector 5: reset in WAIT discards everything, no relaunch.
  task automatic test_reset_mid();
    bit ok1, ok2, ok3;
    int starts;
    do_reset();
    push_set(mk(1, 1, 1, 1, 1, 1), ok1);
    push_set(mk(2, 2, 0, 3, 2, 5), ok2);
    wait_start(ok3);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    n_vec++; if (!(ok1 && ok2 && ok3) || busy !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b1 || op_a !== 16'sd0) begin
      n_bad++; $display("FAIL rst_mid got=busy%b v%b ready%b a%0d exp=busy0 v0 ready1 a0", busy, res_valid, in_ready, op_a);
    end
    Rst = 1'b0;
    starts = 0;
    for (int i = 0; i < 25; i++) begin
      if (Start === 1'b1) starts++;
      @(negedge Clk);
    end
    n_vec++; if (starts != 0) begin n_bad++; $display("FAIL rst_mid_start got=%0d exp=0", starts); end
  endtask

`ifdef HLSM_SEQ_LATMON_EN
  task automatic test_latmon();
    bit ok1, ok2;
    do_reset();
    hlsm_lat = 12;
    push_set(mk(2, 3, 4, 5, 6, 7), ok1);
    wait_start(ok2);
    repeat (13) @(negedge Clk);
    n_vec++; if (!(ok1 && ok2) || res_valid !== 1'b1 || lat_cycles !== 8'd12) begin
      n_bad++; $display("FAIL lat12 got=v%b lat%0d exp=v1 lat12", res_valid, lat_cycles);
    end
  endtask
`endif

  initial begin
    n_vec = 0; n_bad = 0;
    Rst = 1'b1; in_valid = 1'b0; in_ops = '0; res_ready = 1'b1;
    done_en = 1'b1; force_done = 1'b0; hlsm_lat = HLSM_NOM_LAT;
    test_reset();
    test_basic_pair();
    test_back_to_back();
    test_done_ignored();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid();
`ifdef HLSM_SEQ_LATMON_EN
    test_latmon();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
